// File: rtl/mtl_fetch_scheduler_if.sv
// SDRAM burst port between the fetch scheduler (master) and the SDRAM controller (slave).
// Handshake: a burst is presented while oMEM_REQ is high with oMEM_WR/ADDR/LEN stable; it is
// accepted in the cycle iMEM_ACK is high, and iMEM_DONE pulses once when that burst completes
// (possibly in the ACK cycle itself). Only one burst is ever outstanding.
interface mtl_fetch_scheduler_if #(
  parameter int ADDR_W = 23
);
  logic              oMEM_REQ;
  logic              oMEM_WR;
  logic [ADDR_W-1:0] oMEM_ADDR;
  logic [7:0]        oMEM_LEN;
  logic              iMEM_ACK;
  logic              iMEM_DONE;

  modport master (
    output oMEM_REQ, oMEM_WR, oMEM_ADDR, oMEM_LEN,
    input  iMEM_ACK, iMEM_DONE
  );

  modport slave (
    input  oMEM_REQ, oMEM_WR, oMEM_ADDR, oMEM_LEN,
    output iMEM_ACK, iMEM_DONE
  );
endinterface

// File: rtl/mtl_fetch_scheduler.sv
// Shares SDRAM burst bandwidth between the display line prefetcher and the photo-loader writer.
// Display lines are split into bursts; the writer is forced in after WR_SLOT display bursts.
module mtl_fetch_scheduler #(
  parameter int ADDR_W     = 23,
  parameter int LINE_WORDS = 800,
  parameter int BURST_LEN  = 8,
  parameter int WR_SLOT    = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFRAME_START,
  input  logic [ADDR_W-1:0] iDISP_BASE,
  input  logic              iLINE_REQ,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  output logic              oWR_GNT,
  mtl_fetch_scheduler_if.master mem,
  output logic              oLINE_DONE,
  output logic              oUNDERRUN,
  output logic              oBUSY,
  output logic [1:0]        oDBG_STATE,
  output logic [1:0]        oDBG_PEND
);

  localparam int WR_W = $clog2(LINE_WORDS + 1);
  localparam int RC_W = $clog2(WR_SLOT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_pend;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [WR_W-1:0]   r_words_rem;
  logic [RC_W-1:0]   r_run_cnt;
  logic              r_cur_disp;
  logic              r_stale;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_len;
  logic              r_wr_gnt;
  logic              r_line_done;
  logic              r_underrun;
  logic              r_busy;

  logic [7:0] w_disp_len;
  logic       w_done_evt;
  logic       w_disp_upd;
  logic       w_line_end;
  logic       w_line_acc;
  logic       w_wr_pick;
  logic       w_disp_pick;

  always_comb begin
    w_disp_len = 8'(BURST_LEN);
    if (int'(r_words_rem) < BURST_LEN) w_disp_len = 8'(r_words_rem);
  end

  assign w_done_evt  = ((r_state == S_ISSUE) && mem.iMEM_ACK && mem.iMEM_DONE) ||
                       ((r_state == S_WAIT) && mem.iMEM_DONE);
  // A burst started before a frame restart still finishes, but must not touch the new frame.
  assign w_disp_upd  = w_done_evt && r_cur_disp && !r_stale && !iFRAME_START;
  assign w_line_end  = w_disp_upd && (r_words_rem == WR_W'(r_mem_len));
  assign w_line_acc  = iLINE_REQ && (r_pend != 2'd2);
  assign w_wr_pick   = (r_state == S_IDLE) && iWR_REQ &&
                       ((r_pend == 2'd0) || iFRAME_START || (r_run_cnt == RC_W'(WR_SLOT)));
  assign w_disp_pick = (r_state == S_IDLE) && !iFRAME_START && (r_pend != 2'd0) && !w_wr_pick;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_pend      <= 2'd0;
      r_disp_addr <= '0;
      r_words_rem <= WR_W'(LINE_WORDS);
      r_run_cnt   <= '0;
      r_cur_disp  <= 1'b0;
      r_stale     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_len   <= 8'd0;
      r_wr_gnt    <= 1'b0;
      r_line_done <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_gnt    <= 1'b0;
      r_line_done <= 1'b0;
      r_underrun  <= iLINE_REQ && !iFRAME_START && (r_pend == 2'd2);

      // Frame restart empties the queue first, then a coincident request is counted.
      if (iFRAME_START)                   r_pend <= {1'b0, iLINE_REQ};
      else if (w_line_acc && !w_line_end) r_pend <= r_pend + 2'd1;
      else if (!w_line_acc && w_line_end) r_pend <= r_pend - 2'd1;

      case (r_state)
        S_IDLE: begin
          r_stale <= 1'b0;
          if (!iWR_REQ) r_run_cnt <= '0;
          if (w_wr_pick) begin
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b1;
            r_mem_addr <= iWR_ADDR;
            r_mem_len  <= 8'(BURST_LEN);
            r_cur_disp <= 1'b0;
            r_run_cnt  <= '0;
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
          end else if (w_disp_pick) begin
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= r_disp_addr;
            r_mem_len  <= w_disp_len;
            r_cur_disp <= 1'b1;
            if (iWR_REQ && (r_run_cnt != RC_W'(WR_SLOT))) r_run_cnt <= r_run_cnt + RC_W'(1);
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (mem.iMEM_ACK) begin
            r_mem_req <= 1'b0;
            r_wr_gnt  <= r_mem_wr;
            if (mem.iMEM_DONE) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem.iMEM_DONE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_disp_upd) begin
        r_disp_addr <= r_disp_addr + ADDR_W'(r_mem_len);
        if (w_line_end) begin
          r_words_rem <= WR_W'(LINE_WORDS);
          r_line_done <= 1'b1;
        end else begin
          r_words_rem <= r_words_rem - WR_W'(r_mem_len);
        end
      end

      if (iFRAME_START) begin
        r_disp_addr <= iDISP_BASE;
        r_words_rem <= WR_W'(LINE_WORDS);
        if (r_state != S_IDLE) r_stale <= 1'b1;
      end
    end
  end

  assign mem.oMEM_REQ  = r_mem_req;
  assign mem.oMEM_WR   = r_mem_wr;
  assign mem.oMEM_ADDR = r_mem_addr;
  assign mem.oMEM_LEN  = r_mem_len;
  assign oWR_GNT       = r_wr_gnt;
  assign oLINE_DONE    = r_line_done;
  assign oUNDERRUN     = r_underrun;
  assign oBUSY         = r_busy;
  assign oDBG_STATE    = r_state;
  assign oDBG_PEND     = r_pend;

endmodule
